// File: rtl/tpu_share_arbiter.sv
// Shares one weight-ROM port and one TPU_MultAdd between full_connect1 (req 0) and full_connect2 (req 1).
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break; undefined gives fixed priority to requester 0.
module tpu_share_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int ROM_W   = 1024,
    parameter int OPR_W   = 1024,
    parameter int RES_W   = 15,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              iRst,
    input  logic              ena,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [OPR_W-1:0]  opr1_0,
    input  logic [OPR_W-1:0]  opr2_0,
    input  logic [OPR_W-1:0]  opr1_1,
    input  logic [OPR_W-1:0]  opr2_1,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [ROM_W-1:0]  rom_data,
    output logic [ROM_W-1:0]  rdata,
    output logic [1:0]        rvalid,
    output logic [OPR_W-1:0]  ma_opr1,
    output logic [OPR_W-1:0]  ma_opr2,
    input  logic [RES_W-1:0]  ma_res,
    input  logic              ma_ovf,
    output logic [RES_W-1:0]  res,
    output logic [1:0]        ovf_sticky,
    input  logic [1:0]        ovf_clr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

    localparam logic [1:0] TURN_INIT = 2'(ROM_LAT - 1);

    state_t             state_q;
    logic [1:0]         gnt_q;
    logic [1:0]         turn_q;
    logic [1:0]         ovf_q;
    logic [1:0]         ovf_d;
    logic [ROM_LAT-1:0] vld_q;
    logic [ROM_LAT-1:0] tag_q;
    logic               pick1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick1 = 1'b0;
        case (req)
            2'b10:   pick1 = 1'b1;
            2'b11:   pick1 = ~last_q;
            default: pick1 = 1'b0;
        endcase
    end
`else
    assign pick1 = (req == 2'b10);
`endif

    // TURN holds off new grants for ROM_LAT cycles so reads already issued drain to their owner.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            turn_q  <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ena && (req != 2'b00)) begin
                        state_q <= pick1 ? OWN1 : OWN0;
                        gnt_q   <= pick1 ? 2'b10 : 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= pick1;
`endif
                    end
                end
                OWN0: begin
                    if (!req[0]) begin
                        state_q <= TURN;
                        gnt_q   <= 2'b00;
                        turn_q  <= TURN_INIT;
                    end
                end
                OWN1: begin
                    if (!req[1]) begin
                        state_q <= TURN;
                        gnt_q   <= 2'b00;
                        turn_q  <= TURN_INIT;
                    end
                end
                TURN: begin
                    if (turn_q == 2'b00) state_q <= IDLE;
                    else                 turn_q  <= turn_q - 2'b01;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Owner-tag pipe: each ROM access carries its requester to the data-return cycle.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= rom_en;
            tag_q[0] <= gnt_q[1];
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign ovf_d = (ovf_q & ~ovf_clr) | (gnt_q & {2{ma_ovf}});

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) ovf_q <= 2'b00;
        else      ovf_q <= ovf_d;
    end

    assign gnt        = gnt_q;
    assign rom_en     = |gnt_q;
    assign rom_addr   = gnt_q[0] ? addr0  : (gnt_q[1] ? addr1  : '0);
    assign ma_opr1    = gnt_q[0] ? opr1_0 : (gnt_q[1] ? opr1_1 : '0);
    assign ma_opr2    = gnt_q[0] ? opr2_0 : (gnt_q[1] ? opr2_1 : '0);
    assign rdata      = rom_data;
    assign rvalid     = vld_q[ROM_LAT-1] ? (tag_q[ROM_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
    assign res        = ma_res;
    assign ovf_sticky = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tpu_share_arbiter.sv
// Bench for tpu_share_arbiter: scenario tasks plus a ROM-read scoreboard keyed on expected grant per cycle.
module tb_tpu_share_arbiter;

    localparam int ADDR_W = 11;
    localparam int ROM_W  = 32;
    localparam int OPR_W  = 16;
    localparam int RES_W  = 15;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              iRst;
    logic              ena;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [OPR_W-1:0]  opr1_0, opr2_0, opr1_1, opr2_1;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [ROM_W-1:0]  rom_data;
    logic [ROM_W-1:0]  rdata;
    logic [1:0]        rvalid;
    logic [OPR_W-1:0]  ma_opr1, ma_opr2;
    logic [RES_W-1:0]  ma_res;
    logic              ma_ovf;
    logic [RES_W-1:0]  res;
    logic [1:0]        ovf_sticky;
    logic [1:0]        ovf_clr;
    logic              busy;

    typedef struct {
        logic              tag;
        logic [ADDR_W-1:0] addr;
        int                due;
    } rd_t;

    rd_t        sb[$];
    logic [1:0] exp_gnt = 2'b00;
    int         cyc     = 0;
    int         n_checks = 0;
    int         n_pass   = 0;

    tpu_share_arbiter #(
        .ADDR_W(ADDR_W), .ROM_W(ROM_W), .OPR_W(OPR_W), .RES_W(RES_W), .ROM_LAT(LAT)
    ) dut (
        .clk(clk), .iRst(iRst), .ena(ena), .req(req), .gnt(gnt),
        .addr0(addr0), .addr1(addr1),
        .opr1_0(opr1_0), .opr2_0(opr2_0), .opr1_1(opr1_1), .opr2_1(opr2_1),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .rdata(rdata), .rvalid(rvalid),
        .ma_opr1(ma_opr1), .ma_opr2(ma_opr2), .ma_res(ma_res), .ma_ovf(ma_ovf),
        .res(res), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ROM_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a, 5'h15, ~a, 5'h0a};
    endfunction

    // Block ROM model with LAT cycles from address to data.
    logic [ROM_W-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    // Scoreboard: compare due reads, flag unexpected rvalid, then log this cycle's expected read.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            rd_t e;
            e = sb.pop_front();
            n_checks++;
            if (rvalid !== (e.tag ? 2'b10 : 2'b01) || rdata !== rom_word(e.addr))
                $display("FAIL rd_return addr=%0d: rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                         e.addr, rvalid, rdata, (e.tag ? 2'b10 : 2'b01), rom_word(e.addr));
            else
                n_pass++;
        end else if (rvalid !== 2'b00) begin
            n_checks++;
            $display("FAIL rd_unexpected cyc=%0d: rvalid=%b expected 00", cyc, rvalid);
        end
        if (exp_gnt != 2'b00)
            sb.push_back('{tag: exp_gnt[1], addr: (exp_gnt[1] ? addr1 : addr0), due: cyc + LAT});
    end

    task automatic tick(input logic [1:0] eg);
        @(posedge clk);
        #1;
        exp_gnt = eg;
    endtask

    task automatic test_reset;
        iRst = 1'b1; ena = 1'b1; req = 2'b00; ma_ovf = 1'b0; ovf_clr = 2'b00;
        addr0 = '0; addr1 = '0; ma_res = '0;
        opr1_0 = 16'h1111; opr2_0 = 16'h2222; opr1_1 = 16'h3333; opr2_1 = 16'h4444;
        repeat (3) tick(2'b00);
        n_checks++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt); else n_pass++;
        n_checks++; if (rvalid !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", rvalid); else n_pass++;
        n_checks++; if (rom_en !== 1'b0 || rom_addr !== '0) $display("FAIL rst_rom: en=%b addr=%0d want 0/0", rom_en, rom_addr); else n_pass++;
        n_checks++; if (ma_opr1 !== '0 || ma_opr2 !== '0) $display("FAIL rst_opr: %h %h want 0 0", ma_opr1, ma_opr2); else n_pass++;
        n_checks++; if (ovf_sticky !== 2'b00 || busy !== 1'b0) $display("FAIL rst_ovf_busy: ovf=%b busy=%b want 00/0", ovf_sticky, busy); else n_pass++;
        iRst = 1'b0;
        tick(2'b00);
    endtask

    task automatic test_single_read;
        addr0 = 11'd5; ma_res = 15'h1abc; req = 2'b01;
        tick(2'b01);
        n_checks++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else n_pass++;
        n_checks++; if (rom_addr !== 11'd5 || rom_en !== 1'b1) $display("FAIL single_rom: addr=%0d en=%b want 5/1", rom_addr, rom_en); else n_pass++;
        n_checks++; if (ma_opr1 !== 16'h1111 || ma_opr2 !== 16'h2222 || res !== 15'h1abc)
            $display("FAIL single_ma: opr1=%h opr2=%h res=%h want 1111 2222 1abc", ma_opr1, ma_opr2, res); else n_pass++;
        n_checks++; if (ovf_sticky !== 2'b00) $display("FAIL single_ovf: got %b want 00", ovf_sticky); else n_pass++;
        req = 2'b00;
        for (int i = 0; i <= LAT; i++) begin
            tick(2'b00);
            n_checks++;
            if (gnt !== 2'b00 || busy !== (i < LAT))
                $display("FAIL single_turn[%0d]: gnt=%b busy=%b want 00/%b", i, gnt, busy, (i < LAT));
            else n_pass++;
        end
    endtask

    task automatic test_priority_handover;
        logic       w;
        logic [1:0] wv, lv;
`ifdef ARB_ROUND_ROBIN_EN
        w = 1'b1;
`else
        w = 1'b0;
`endif
        wv = w ? 2'b10 : 2'b01;
        lv = w ? 2'b01 : 2'b10;
        addr0 = 11'd20; addr1 = 11'd40; req = 2'b11;
        tick(wv);
        n_checks++; if (gnt !== wv) $display("FAIL tie_gnt: got %b want %b", gnt, wv); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            addr0 = addr0 + 11'd1; addr1 = addr1 + 11'd1;
            tick(wv);
        end
        req = lv;
        for (int i = 0; i <= LAT; i++) begin
            tick(2'b00);
            n_checks++; if (gnt !== 2'b00) $display("FAIL handover_gap[%0d]: got %b want 00", i, gnt); else n_pass++;
        end
        tick(lv);
        n_checks++; if (gnt !== lv) $display("FAIL handover_gnt: got %b want %b", gnt, lv); else n_pass++;
        addr0 = 11'd99; addr1 = 11'd123;
        tick(lv);
        n_checks++; if (rom_addr !== (w ? 11'd99 : 11'd123)) $display("FAIL handover_addr: got %0d", rom_addr); else n_pass++;
        req = 2'b00;
        repeat (LAT + 1) tick(2'b00);
    endtask

    task automatic test_ovf;
        req = 2'b10;
        tick(2'b10);
        n_checks++; if (ma_opr1 !== 16'h3333 || ma_opr2 !== 16'h4444) $display("FAIL ovf_opr: %h %h want 3333 4444", ma_opr1, ma_opr2); else n_pass++;
        ma_ovf = 1'b1;
        tick(2'b10);
        ma_ovf = 1'b0;
        n_checks++; if (ovf_sticky !== 2'b10) $display("FAIL ovf_set: got %b want 10", ovf_sticky); else n_pass++;
        tick(2'b10);
        n_checks++; if (ovf_sticky !== 2'b10) $display("FAIL ovf_hold: got %b want 10", ovf_sticky); else n_pass++;
        ovf_clr = 2'b10;
        tick(2'b10);
        ovf_clr = 2'b00;
        n_checks++; if (ovf_sticky !== 2'b00) $display("FAIL ovf_clr: got %b want 00", ovf_sticky); else n_pass++;
        ovf_clr = 2'b10; ma_ovf = 1'b1;
        tick(2'b10);
        ovf_clr = 2'b00; ma_ovf = 1'b0;
        n_checks++; if (ovf_sticky !== 2'b10) $display("FAIL ovf_set_wins: got %b want 10", ovf_sticky); else n_pass++;
        req = 2'b00;
        repeat (LAT + 1) tick(2'b00);
        n_checks++; if (ovf_sticky !== 2'b10) $display("FAIL ovf_after_release: got %b want 10", ovf_sticky); else n_pass++;
    endtask

    task automatic test_ena;
        ena = 1'b0; req = 2'b01; addr0 = 11'd300;
        for (int i = 0; i < 3; i++) begin
            tick(2'b00);
            n_checks++; if (gnt !== 2'b00) $display("FAIL ena_block[%0d]: got %b want 00", i, gnt); else n_pass++;
        end
        ena = 1'b1;
        tick(2'b01);
        n_checks++; if (gnt !== 2'b01) $display("FAIL ena_grant: got %b want 01", gnt); else n_pass++;
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(2'b01);
            n_checks++; if (gnt !== 2'b01) $display("FAIL ena_retain[%0d]: got %b want 01", i, gnt); else n_pass++;
        end
        req = 2'b00;
        repeat (LAT + 1) tick(2'b00);
        ena = 1'b1;
    endtask

    task automatic test_reset_mid;
        req = 2'b10; addr1 = 11'd77;
        tick(2'b10);
        addr1 = 11'd78;
        tick(2'b10);
        #1;
        iRst = 1'b1; exp_gnt = 2'b00; sb.delete();
        #1;
        n_checks++; if (gnt !== 2'b00 || rom_en !== 1'b0) $display("FAIL midrst_gnt: gnt=%b en=%b want 00/0", gnt, rom_en); else n_pass++;
        n_checks++; if (rvalid !== 2'b00 || busy !== 1'b0) $display("FAIL midrst_rvalid: rvalid=%b busy=%b want 00/0", rvalid, busy); else n_pass++;
        req = 2'b00;
        repeat (2) tick(2'b00);
        iRst = 1'b0;
        repeat (LAT + 1) tick(2'b00);
        n_checks++; if (busy !== 1'b0 || ovf_sticky !== 2'b00) $display("FAIL midrst_idle: busy=%b ovf=%b want 0/00", busy, ovf_sticky); else n_pass++;
        req = 2'b01; addr0 = 11'd500;
        tick(2'b01);
        n_checks++; if (gnt !== 2'b01) $display("FAIL midrst_regrant: got %b want 01", gnt); else n_pass++;
        req = 2'b00;
        repeat (LAT + 1) tick(2'b00);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_handover();
        test_ovf();
        test_ena();
        test_reset_mid();
        repeat (LAT + 2) tick(2'b00);
        n_checks++; if (sb.size() != 0) $display("FAIL sb_drain: %0d reads never returned", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tpu_share_arbiter.md
Name: tpu_share_arbiter

Overview:
- Arbitrates the single weight ROM port and the single TPU_MultAdd unit between two layer engines: requester 0 is full_connect1, requester 1 is full_connect2.
- Replaces the tri-state (z) sharing with registered request/grant ownership, explicit muxes, and ROM read-data routing that accounts for read latency.
- Sits between the layer engines and block_mem / TPU_MultAdd, under the top-level TPU sequencer.

Parameters:
- ADDR_W, 11, ROM address width
- ROM_W, 1024, ROM data width
- OPR_W, 1024, width of each MultAdder operand (128 x 8 bit)
- RES_W, 15, MultAdder result width
- ROM_LAT, 1, ROM read latency in cycles (1..3)

Ports:
- clk  in  1  clock
- iRst  in  1  asynchronous reset, active-high
- ena  in  1  arbiter enable; low = no new grants, current owner keeps its grant
- req  in  2  per-requester request, level
- gnt  out  2  one-hot-or-zero grant
- addr0, addr1  in  ADDR_W each  ROM address from requester 0 / 1
- opr1_0, opr2_0, opr1_1, opr2_1  in  OPR_W each  MultAdder operands per requester
- rom_addr  out  ADDR_W  to block_mem addra
- rom_en  out  1  to block_mem ena
- rom_data  in  ROM_W  from block_mem douta
- rdata  out  ROM_W  ROM data broadcast to both requesters
- rvalid  out  2  per-requester ROM data valid
- ma_opr1, ma_opr2  out  OPR_W each  to TPU_MultAdd
- ma_res  in  RES_W  from TPU_MultAdd
- ma_ovf  in  1  from TPU_MultAdd
- res  out  RES_W  MultAdder result broadcast
- ovf_sticky  out  2  per-requester sticky overflow
- ovf_clr  in  2  per-requester sticky-overflow clear
- busy  out  1  high while any grant is active or a turnaround is in progress

Behaviour:
- Reset values: gnt=0, rvalid=0, rom_en=0, rom_addr=0, ma_opr1=0, ma_opr2=0, ovf_sticky=0, busy=0, state=IDLE, latency pipe cleared. No output is ever driven to z.
- FSM states: IDLE, OWN0, OWN1, TURN.
  - IDLE: if ena and req != 0, pick a winner by policy and go to OWNn; gnt[n] goes high on the next cycle.
  - OWNn: hold while req[n]=1, regardless of ena. When req[n] falls, go to TURN.
  - TURN: lasts ROM_LAT cycles so in-flight reads drain, then go to IDLE. No new grant is issued during TURN.
  - Grant-to-grant gap for a handover is therefore ROM_LAT+1 cycles.
- Muxing (combinational on registered gnt):
  - rom_addr, ma_opr1 and ma_opr2 come from the granted requester, else 0.
  - rom_en = |gnt.
- Read tagging:
  - A ROM_LAT-deep shift register carries the owner tag for each cycle in which rom_en=1.
  - rvalid[tag] = 1 exactly ROM_LAT cycles after the address cycle; rdata = rom_data.
  - A read issued in the last owned cycle still returns to that owner during TURN.
- MultAdder:
  - res = ma_res, combinational and valid the same cycle the operands are presented.
  - ovf_sticky[n] is set on a clock edge where gnt[n]=1 and ma_ovf=1.
  - ovf_sticky[n] is cleared by ovf_clr[n]; if set and clear hit the same cycle, set wins.
- Requests with ena=0 are ignored in IDLE; the request stays pending and is not lost.
- req[n] falling and rising again in the same cycle is not possible (level signal); a re-request after release is arbitrated anew after TURN.
- iRst mid-operation drops gnt immediately, without waiting for a clock edge, and discards in-flight tags (no rvalid is issued).

Optional Feature:
- ARB_ROUND_ROBIN_EN
  - Defined: round-robin. On a tie in IDLE, the requester not granted last wins. The last-granted pointer resets to 1, so requester 0 wins the first tie.
  - Undefined: fixed priority. Requester 0 (FC1) always wins ties.

Test Plan:
- Reset, then req=2'b01, addr0=5 -> gnt=01 after 1 cycle, rom_addr=5, rvalid=01 ROM_LAT cycles later carrying word 5; ovf_sticky=00.
- req=2'b11 from IDLE -> fixed priority: gnt=01. With ARB_ROUND_ROBIN_EN after a prior FC1 grant: gnt=10.
- Owner 0 drops req with a read issued in its last cycle while req[1]=1 -> rvalid[0] pulses during TURN; gnt=10 exactly ROM_LAT+1 cycles after the drop; no rvalid[1] for the stale read.
- gnt=10, ma_ovf=1 for one cycle -> ovf_sticky=10 and held. ovf_clr=10 -> 00. ovf_clr=10 together with ma_ovf=1 -> stays 10.
- ena=0 with req=01 in IDLE -> gnt stays 00. Raising ena -> gnt=01 next cycle. ena dropped while owning -> grant retained.
- iRst pulse during OWN1 with a read in flight -> gnt=00, rvalid=00 immediately; after release, state is IDLE and no stale rvalid appears.
